result_slot_scheduler: RTL and testbench
========================================

// Module: result_slot_scheduler
// PURPOSE
// - Shares the output result region between NUM_REQ match engines (MAC/IP/port/URL flaggers).
// - Grants one requester at a time in round-robin order and allocates it the next free result slot.
//   - Slots form a ring of NUM_SLOTS fixed-size regions; slot base = slot_idx * SLOT_STRIDE.
// - Tracks slot occupancy: the host side frees slots oldest-first, so unread results are never overwritten.
// PARAMETERS
// - NUM_REQ      4      number of requesting match engines
// - NUM_SLOTS    5      result slots in the ring
// - SLOT_STRIDE  1550   bytes per slot; address = idx * SLOT_STRIDE
// PORTS
// - clk           in   1                    system clock, rising edge
// - n_rst         in   1                    async active-low reset
// - req           in   NUM_REQ              level request per engine, held until its gnt pulse
// - release_slot  in   1                    1-cycle pulse: host has drained the oldest occupied slot
// - gnt           out  NUM_REQ              one-hot 1-cycle grant
// - write_enable  out  1                    1-cycle pulse, coincident with gnt
// - addr_out      out  32                   base address of the slot being granted; holds last value otherwise
// - rd_addr       out  32                   base address of the oldest occupied slot (host read pointer)
// - slot_count    out  $clog2(NUM_SLOTS+1)  occupied slots
// - full          out  1                    slot_count == NUM_SLOTS
// - empty         out  1                    slot_count == 0
// BEHAVIOUR
// - Clock and reset: one clock domain, clk. Reset is asynchronous, active-low (n_rst).
// - Reset values:
//   - state = IDLE; gnt = 0; write_enable = 0.
//   - addr_out = 0; rd_addr = 0; wr_ptr = rd_ptr = 0.
//   - slot_count = 0; empty = 1; full = 0.
//   - rr_ptr = 0, so requester 0 has the highest priority first.
// - FSM states:
//   - IDLE: if |req && !full -> GRANT.
//     - Winner = first set req bit at or after rr_ptr, wrapping.
//     - The winner is latched on the IDLE->GRANT edge.
//   - GRANT (exactly 1 cycle):
//     - gnt[winner] = 1, write_enable = 1, addr_out = wr_ptr * SLOT_STRIDE.
//     - wr_ptr advances, wrapping NUM_SLOTS-1 -> 0.
//     - rr_ptr = winner+1 mod NUM_REQ.
//     - slot_count increments. -> SETTLE.
//   - SETTLE (1 cycle): lets the granted engine drop req; no grant issued. -> IDLE.
//   - Consequence: at most one grant every 3 cycles.
// - Latency: req rising in IDLE (not full) -> gnt/write_enable registered exactly 1 cycle later.
// - Outputs are registered. addr_out changes only in GRANT, then holds. rd_addr always = rd_ptr * SLOT_STRIDE.
// - release_slot:
//   - When !empty: rd_ptr advances with wrap, slot_count decrements.
//   - When empty: ignored, no state change.
// - Simultaneous GRANT and release in the same cycle:
//   - Both pointers advance; slot_count is unchanged.
//   - A release on the cycle the count would reach full still counts.
// - full:
//   - No IDLE->GRANT transition; req is held pending and no request is dropped.
//   - A release on cycle N permits the IDLE->GRANT transition at edge N+1.
// - Address arithmetic:
//   - Computed unsigned in 32 bits; no overflow for the defaults (max 6200).
//   - Either a constant table or a multiply is acceptable.
// - An engine deasserting req before its grant simply loses its turn; this is not an error.
// - Reset mid-GRANT aborts the pulse immediately (async) and discards all occupancy. The host must re-sync.
// STRUCTURE
// - sniffer_pkg holds:
//   - typedef enum logic [1:0] {IDLE, GRANT, SETTLE} sched_state_t;
//   - localparam SLOT_STRIDE_DEFAULT = 1550.
// - Sub-module rr_arbiter: combinational priority rotate from req and rr_ptr, giving a one-hot winner and a valid flag.
// - Pointer, count and FSM logic stay in this module.
// TESTING
// - Single req[2] after reset -> gnt=4'b0100, write_enable=1, addr_out=0 one cycle later; slot_count=1.
// - req=4'b1111 held:
//   - grant order is 0,1,2,3,0; addr_out = 0, 0x060E, 0x0C1C, 0x122A, 0x1838.
//   - full=1 after the 5th grant; no 6th grant.
// - Full, req[1] pending, release_slot pulse:
//   - slot_count 5->4, rd_addr = 0x060E.
//   - gnt[1] next cycle with addr_out = 0 (wrap); full=1 again.
// - release_slot in the same cycle as GRANT with count=3 -> count stays 3; wr_ptr and rd_ptr both advance.
// - release_slot while empty -> no change (count 0, rd_addr 0).
//   - Then n_rst low during GRANT -> gnt and write_enable drop asynchronously; all counters are 0.

Source files
------------

// File: rtl/sniffer_pkg.sv
// Shared types and constants for the result-slot scheduler.
package sniffer_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE} sched_state_t;

  localparam int SLOT_STRIDE_DEFAULT = 1550;

  function automatic logic [31:0] slot_base(input logic [31:0] idx, input logic [31:0] stride);
    return idx * stride;
  endfunction

endpackage

// File: rtl/result_slot_scheduler_rr_arbiter.sv
// Round-robin priority pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [RW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [RW-1:0]      winner_idx,
  output logic               valid
);

  always_comb begin
    int idx;
    idx        = 0;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = RW'(idx);
      end
    end
  end

endmodule

// File: rtl/result_slot_scheduler.sv
// Grants match engines round-robin and hands each the next free slot of the result ring.
//
// state  | meaning
// IDLE   | waiting for a request while the ring has a free slot
// GRANT  | one-cycle gnt/write_enable pulse; pointer and count update at its end
// SETTLE | gap cycle so the granted engine can drop its request
module result_slot_scheduler
  import sniffer_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SLOTS   = 5,
  parameter int SLOT_STRIDE = SLOT_STRIDE_DEFAULT
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic                             release_slot,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             write_enable,
  output logic [31:0]                      addr_out,
  output logic [31:0]                      rd_addr,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   slot_count,
  output logic                             full,
  output logic                             empty
);

  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_SLOTS - 1);
  localparam logic [RW-1:0] LAST_REQ  = RW'(NUM_REQ - 1);

  sched_state_t         state;
  logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [RW-1:0]        rr_ptr, arb_idx;
  logic [NUM_REQ-1:0]   arb_winner;
  logic                 arb_valid, do_inc, do_dec;
  logic [CW-1:0]        count_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  // A release landing in the GRANT cycle cancels that cycle's increment.
  always_comb begin
    do_inc     = (state == GRANT);
    do_dec     = release_slot && (slot_count != '0);
    rd_ptr_nxt = rd_ptr;
    if (do_dec) rd_ptr_nxt = (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
    count_nxt = slot_count;
    if (do_inc && !do_dec)      count_nxt = slot_count + 1'b1;
    else if (!do_inc && do_dec) count_nxt = slot_count - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      gnt          <= '0;
      write_enable <= 1'b0;
      addr_out     <= '0;
      rd_addr      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rr_ptr       <= '0;
      slot_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      rd_addr    <= slot_base(32'(rd_ptr_nxt), 32'(SLOT_STRIDE));
      slot_count <= count_nxt;
      full       <= (count_nxt == CW'(NUM_SLOTS));
      empty      <= (count_nxt == '0);
      if (do_inc) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (arb_valid && !full) begin
            state        <= GRANT;
            gnt          <= arb_winner;
            write_enable <= 1'b1;
            addr_out     <= slot_base(32'(wr_ptr), 32'(SLOT_STRIDE));
            rr_ptr       <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
          end
        end
        GRANT: begin
          state        <= SETTLE;
          gnt          <= '0;
          write_enable <= 1'b0;
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_slot_scheduler.sv
// Randomized and directed bench for result_slot_scheduler against a cycle-level reference model.
module tb_result_slot_scheduler;

  localparam int NR     = 4;
  localparam int NS     = 5;
  localparam int STRIDE = 1550;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  req;
  logic        release_slot;
  logic [3:0]  gnt;
  logic        write_enable;
  logic [31:0] addr_out, rd_addr;
  logic [2:0]  slot_count;
  logic        full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_count, m_wr, m_rd, m_rr, m_cool;
  bit          m_pend;
  logic [3:0]  m_gnt;
  logic        m_we;
  logic [31:0] m_addr;

  result_slot_scheduler #(.NUM_REQ(NR), .NUM_SLOTS(NS), .SLOT_STRIDE(STRIDE)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req          (req),
    .release_slot (release_slot),
    .gnt          (gnt),
    .write_enable (write_enable),
    .addr_out     (addr_out),
    .rd_addr      (rd_addr),
    .slot_count   (slot_count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_count = 0; m_wr = 0; m_rd = 0; m_rr = 0; m_cool = 0; m_pend = 0;
    m_gnt = '0; m_we = 1'b0; m_addr = '0;
  endtask

  // One clock edge of the scheduler rules: a grant needs a request, a free slot,
  // and two quiet cycles since the previous grant; occupancy counts the grant one edge later.
  task automatic step_model();
    int  old_count, w;
    bit  inc, dec;
    old_count = m_count;
    inc = m_pend;
    m_pend = 1'b0;
    dec = release_slot && (old_count > 0);
    m_gnt = '0;
    m_we  = 1'b0;
    if (m_cool > 0) m_cool--;
    else if (req != '0 && old_count < NS) begin
      w = -1;
      for (int i = 0; i < NR; i++) begin
        if (w < 0 && req[(m_rr + i) % NR]) w = (m_rr + i) % NR;
      end
      m_gnt[w] = 1'b1;
      m_we     = 1'b1;
      m_addr   = 32'(m_wr * STRIDE);
      m_rr     = (w + 1) % NR;
      m_pend   = 1'b1;
      m_cool   = 2;
    end
    if (inc) m_wr = (m_wr + 1) % NS;
    if (dec) m_rd = (m_rd + 1) % NS;
    m_count = old_count + int'(inc) - int'(dec);
  endtask

  task automatic compare_all();
    check_val("gnt",          32'(gnt),          32'(m_gnt));
    check_val("write_enable", 32'(write_enable), 32'(m_we));
    check_val("addr_out",     addr_out,          m_addr);
    check_val("rd_addr",      rd_addr,           32'(m_rd * STRIDE));
    check_val("slot_count",   32'(slot_count),   32'(m_count));
    check_val("full",         32'(full),         32'(m_count == NS));
    check_val("empty",        32'(empty),        32'(m_count == 0));
  endtask

  // Inputs change on the falling edge; engines drop a request once granted.
  task automatic cycle();
    @(posedge clk);
    step_model();
    @(negedge clk);
    compare_all();
    req = req & ~gnt;
    release_slot = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    req = '0;
    release_slot = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    n_rst = 1'b1;
  endtask

  int g_idx[$];
  int g_addr[$];
  int ng;

  initial begin
    int exp_idx[5];
    exp_idx = '{0, 1, 2, 3, 0};
    n_rst = 1'b0;
    req = '0;
    release_slot = 1'b0;

    // single requester after reset
    do_reset();
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_count", 32'(slot_count), 32'd0);
    req = 4'b0100;
    cycle();
    check_val("t1_gnt", 32'(gnt), 32'h4);
    check_val("t1_we", 32'(write_enable), 32'd1);
    check_val("t1_addr", addr_out, 32'd0);
    cycle();
    check_val("t1_count", 32'(slot_count), 32'd1);
    repeat (3) cycle();

    // all engines held high: fill the ring
    do_reset();
    for (int k = 0; k < 18; k++) begin
      req = 4'b1111;
      cycle();
      if (gnt != '0) begin
        for (int e = 0; e < NR; e++) if (gnt[e]) g_idx.push_back(e);
        g_addr.push_back(int'(addr_out));
      end
    end
    check_val("t2_ngrants", 32'(g_idx.size()), 32'd5);
    for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
      check_val("t2_order", 32'(g_idx[k]), 32'(exp_idx[k]));
      check_val("t2_addr", 32'(g_addr[k]), 32'(k * 1550));
    end
    check_val("t2_full", 32'(full), 32'd1);

    // full with req[1] pending, then one release
    req = 4'b0010;
    repeat (3) cycle();
    check_val("t3_held", 32'(gnt), 32'd0);
    release_slot = 1'b1;
    cycle();
    check_val("t3_count", 32'(slot_count), 32'd4);
    check_val("t3_rd_addr", rd_addr, 32'h060E);
    cycle();
    check_val("t3_gnt", 32'(gnt), 32'h2);
    check_val("t3_addr", addr_out, 32'd0);
    cycle();
    check_val("t3_full", 32'(full), 32'd1);
    repeat (3) cycle();

    // release coinciding with the GRANT cycle at count 3
    do_reset();
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      req = 4'b0001;
      cycle();
      if (gnt != '0) ng++;
    end
    check_val("t4_ngrants", 32'(ng), 32'd4);
    check_val("t4_pre_count", 32'(slot_count), 32'd3);
    release_slot = 1'b1;
    cycle();
    check_val("t4_count", 32'(slot_count), 32'd3);
    check_val("t4_rd_addr", rd_addr, 32'd1550);
    ng = 0;
    for (int k = 0; k < 10 && ng < 1; k++) begin
      req = 4'b0001;
      cycle();
      if (gnt != '0) ng++;
    end
    check_val("t4_next_addr", addr_out, 32'd6200);
    repeat (3) cycle();

    // release while empty, then async reset in the middle of a grant
    do_reset();
    release_slot = 1'b1;
    cycle();
    check_val("t5_count", 32'(slot_count), 32'd0);
    check_val("t5_rd_addr", rd_addr, 32'd0);
    req = 4'b1000;
    ng = 0;
    for (int k = 0; k < 10 && ng < 1; k++) begin
      cycle();
      if (gnt != '0) ng++;
    end
    check_val("t5_granted", 32'(ng), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check_val("t5_rst_gnt", 32'(gnt), 32'd0);
    check_val("t5_rst_we", 32'(write_enable), 32'd0);
    check_val("t5_rst_count", 32'(slot_count), 32'd0);
    check_val("t5_rst_addr", addr_out, 32'd0);
    check_val("t5_rst_empty", 32'(empty), 32'd1);
    do_reset();

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      for (int e = 0; e < NR; e++) begin
        if (!req[e] && $urandom_range(3) == 0) req[e] = 1'b1;
        else if (req[e] && $urandom_range(31) == 0) req[e] = 1'b0;
      end
      release_slot = ($urandom_range(2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
